// File: rtl/bsg_dramsim3_ch_arbiter.sv
// Round-robin arbiter that shares one DRAM channel among several requesters.
// Read tags and write ids are queued in issue order so returning read data and
// outgoing write data are routed to the right requester.
module bsg_dramsim3_ch_arbiter #(
    parameter int num_req_p            = 4,
    parameter int channel_addr_width_p = 29,
    parameter int data_width_p         = 256,
    parameter int fifo_els_p           = 16
) (
    input  logic                                       clk,
    input  logic                                       reset,

    input  logic [num_req_p-1:0]                       req_v_i,
    input  logic [num_req_p-1:0]                       req_write_not_read_i,
    input  logic [num_req_p*channel_addr_width_p-1:0]  req_ch_addr_i,
    output logic [num_req_p-1:0]                       req_yumi_o,

    input  logic [num_req_p-1:0]                       req_data_v_i,
    input  logic [num_req_p*data_width_p-1:0]          req_data_i,
    output logic [num_req_p-1:0]                       req_data_yumi_o,

    output logic [num_req_p-1:0]                       resp_v_o,
    output logic [data_width_p-1:0]                    resp_data_o,

    output logic                                       mem_v_o,
    output logic                                       mem_write_not_read_o,
    output logic [channel_addr_width_p-1:0]            mem_ch_addr_o,
    input  logic                                       mem_yumi_i,

    output logic                                       mem_data_v_o,
    output logic [data_width_p-1:0]                    mem_data_o,
    input  logic                                       mem_data_yumi_i,

    input  logic                                       mem_data_v_i,
    input  logic [data_width_p-1:0]                    mem_data_i,

    output logic                                       error_o
);

    localparam int idx_w_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    localparam int ptr_w_lp = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
    localparam int cnt_w_lp = ptr_w_lp + 1;
    localparam logic [cnt_w_lp-1:0] full_cnt_lp = cnt_w_lp'(fifo_els_p);
    localparam logic [idx_w_lp-1:0] last_idx_lp = idx_w_lp'(num_req_p - 1);

    // reset is active-low: outputs are only live while it is high
    logic run;
    assign run = reset;

    // round-robin pointer
    logic [idx_w_lp-1:0] rr_q, rr_d;

    // read-tag FIFO
    logic [idx_w_lp-1:0] rt_mem_q [fifo_els_p];
    logic [ptr_w_lp-1:0] rt_rptr_q, rt_rptr_d, rt_wptr_q, rt_wptr_d;
    logic [cnt_w_lp-1:0] rt_cnt_q, rt_cnt_d;

    // write-id FIFO
    logic [idx_w_lp-1:0] wi_mem_q [fifo_els_p];
    logic [ptr_w_lp-1:0] wi_rptr_q, wi_rptr_d, wi_wptr_q, wi_wptr_d;
    logic [cnt_w_lp-1:0] wi_cnt_q, wi_cnt_d;

    logic error_q, error_d;

    logic                            grant_found;
    logic [idx_w_lp-1:0]             grant_idx;
    logic                            grant_wnr;
    logic [channel_addr_width_p-1:0] grant_addr;
    logic [idx_w_lp-1:0]             rt_head, wi_head;
    logic [data_width_p-1:0]         wi_data;
    logic                            wi_data_v;
    logic                            rt_empty, rt_full, wi_empty, wi_full;
    logic                            rt_push, rt_pop, wi_push, wi_pop;
    logic                            accept;

    assign rt_empty = (rt_cnt_q == '0);
    assign rt_full  = (rt_cnt_q == full_cnt_lp);
    assign wi_empty = (wi_cnt_q == '0);
    assign wi_full  = (wi_cnt_q == full_cnt_lp);
    assign rt_head  = rt_mem_q[rt_rptr_q];
    assign wi_head  = wi_mem_q[wi_rptr_q];

    // first valid requester at or after the priority pointer, wrapping around
    always_comb begin
        logic [idx_w_lp-1:0] cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = rr_q;
        for (int k = 0; k < num_req_p; k++) begin
            if (!grant_found && req_v_i[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
            cand = (cand == last_idx_lp) ? '0 : cand + 1'b1;
        end
    end

    // select command fields of the granted requester and data of the write-id head
    always_comb begin
        grant_wnr  = 1'b0;
        grant_addr = '0;
        wi_data    = '0;
        wi_data_v  = 1'b0;
        for (int k = 0; k < num_req_p; k++) begin
            if (grant_idx == idx_w_lp'(k)) begin
                grant_wnr  = req_write_not_read_i[k];
                grant_addr = req_ch_addr_i[k*channel_addr_width_p +: channel_addr_width_p];
            end
            if (wi_head == idx_w_lp'(k)) begin
                wi_data   = req_data_i[k*data_width_p +: data_width_p];
                wi_data_v = req_data_v_i[k];
            end
        end
    end

    // a pop in the same cycle frees a full FIFO, so issue is not blocked by it
    assign rt_pop       = run & mem_data_v_i & ~rt_empty;
    assign mem_data_v_o = run & ~wi_empty & wi_data_v;
    assign wi_pop       = mem_data_yumi_i & mem_data_v_o;

    assign mem_v_o              = run & grant_found & (~rt_full | rt_pop) & (~wi_full | wi_pop);
    assign mem_write_not_read_o = run & grant_wnr;
    assign mem_ch_addr_o        = run ? grant_addr : '0;
    assign accept               = mem_v_o & mem_yumi_i;
    assign rt_push              = accept & ~grant_wnr;
    assign wi_push              = accept & grant_wnr;

    assign req_yumi_o      = accept ? (num_req_p'(1) << grant_idx) : '0;
    assign req_data_yumi_o = wi_pop ? (num_req_p'(1) << wi_head)   : '0;
    assign mem_data_o      = run ? wi_data : '0;
    assign resp_v_o        = rt_pop ? (num_req_p'(1) << rt_head)   : '0;
    assign resp_data_o     = mem_data_i;
    assign error_o         = error_q;

    // next-state for pointer, FIFO bookkeeping and sticky error
    always_comb begin
        rr_d      = rr_q;
        rt_rptr_d = rt_rptr_q;
        rt_wptr_d = rt_wptr_q;
        rt_cnt_d  = rt_cnt_q;
        wi_rptr_d = wi_rptr_q;
        wi_wptr_d = wi_wptr_q;
        wi_cnt_d  = wi_cnt_q;
        if (accept) begin
            rr_d = (grant_idx == last_idx_lp) ? '0 : grant_idx + 1'b1;
        end
        if (rt_push) rt_wptr_d = rt_wptr_q + 1'b1;
        if (rt_pop)  rt_rptr_d = rt_rptr_q + 1'b1;
        if (rt_push && !rt_pop) rt_cnt_d = rt_cnt_q + 1'b1;
        if (!rt_push && rt_pop) rt_cnt_d = rt_cnt_q - 1'b1;
        if (wi_push) wi_wptr_d = wi_wptr_q + 1'b1;
        if (wi_pop)  wi_rptr_d = wi_rptr_q + 1'b1;
        if (wi_push && !wi_pop) wi_cnt_d = wi_cnt_q + 1'b1;
        if (!wi_push && wi_pop) wi_cnt_d = wi_cnt_q - 1'b1;
        error_d = error_q
                | (mem_data_v_i & rt_empty)
                | (mem_data_yumi_i & ~mem_data_v_o);
    end

    // control registers, cleared by reset (discards any outstanding tags)
    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_q      <= '0;
            rt_rptr_q <= '0;
            rt_wptr_q <= '0;
            rt_cnt_q  <= '0;
            wi_rptr_q <= '0;
            wi_wptr_q <= '0;
            wi_cnt_q  <= '0;
            error_q   <= 1'b0;
        end else begin
            rr_q      <= rr_d;
            rt_rptr_q <= rt_rptr_d;
            rt_wptr_q <= rt_wptr_d;
            rt_cnt_q  <= rt_cnt_d;
            wi_rptr_q <= wi_rptr_d;
            wi_wptr_q <= wi_wptr_d;
            wi_cnt_q  <= wi_cnt_d;
            error_q   <= error_d;
        end
    end

    // FIFO storage; entries are only meaningful below the counts, so no reset
    always_ff @(posedge clk) begin
        if (rt_push) rt_mem_q[rt_wptr_q] <= grant_idx;
        if (wi_push) wi_mem_q[wi_wptr_q] <= grant_idx;
    end

endmodule

// File: tb/tb_bsg_dramsim3_ch_arbiter.sv
// Testbench for bsg_dramsim3_ch_arbiter: vector table, corner-case sequences
// and a randomized run against a queue-based reference model.
module tb_bsg_dramsim3_ch_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int AW = 29;
    localparam int DW = 256;
    localparam int FE = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic [N-1:0]    req_v_i, req_write_not_read_i, req_yumi_o;
    logic [N*AW-1:0] req_ch_addr_i;
    logic [N-1:0]    req_data_v_i, req_data_yumi_o, resp_v_o;
    logic [N*DW-1:0] req_data_i;
    logic [DW-1:0]   resp_data_o, mem_data_o, mem_data_i;
    logic            mem_v_o, mem_write_not_read_o, mem_yumi_i;
    logic [AW-1:0]   mem_ch_addr_o;
    logic            mem_data_v_o, mem_data_yumi_i, mem_data_v_i, error_o;

    bsg_dramsim3_ch_arbiter #(
        .num_req_p(N), .channel_addr_width_p(AW), .data_width_p(DW), .fifo_els_p(FE)
    ) dut (
        .clk(clk), .reset(reset),
        .req_v_i(req_v_i), .req_write_not_read_i(req_write_not_read_i),
        .req_ch_addr_i(req_ch_addr_i), .req_yumi_o(req_yumi_o),
        .req_data_v_i(req_data_v_i), .req_data_i(req_data_i),
        .req_data_yumi_o(req_data_yumi_o),
        .resp_v_o(resp_v_o), .resp_data_o(resp_data_o),
        .mem_v_o(mem_v_o), .mem_write_not_read_o(mem_write_not_read_o),
        .mem_ch_addr_o(mem_ch_addr_o), .mem_yumi_i(mem_yumi_i),
        .mem_data_v_o(mem_data_v_o), .mem_data_o(mem_data_o),
        .mem_data_yumi_i(mem_data_yumi_i),
        .mem_data_v_i(mem_data_v_i), .mem_data_i(mem_data_i),
        .error_o(error_o)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] addr_of(input int i);
        return AW'(32'h1000 + 32'(i) * 32'h80);
    endfunction

    function automatic logic [DW-1:0] dat_of(input int i);
        return {8{32'hD000_0000 + 32'(i)}};
    endfunction

    task automatic set_fixed_payload();
        for (int i = 0; i < N; i++) begin
            req_ch_addr_i[i*AW +: AW] = addr_of(i);
            req_data_i[i*DW +: DW]    = dat_of(i);
        end
        mem_data_i = {8{32'h5EED_0042}};
    endtask

    task automatic drive(input logic [N-1:0] rv, input logic [N-1:0] wnr, input logic [N-1:0] dv,
                         input logic my, input logic mdy, input logic mdv);
        req_v_i              = rv;
        req_write_not_read_i = wnr;
        req_data_v_i         = dv;
        mem_yumi_i           = my;
        mem_data_yumi_i      = mdy;
        mem_data_v_i         = mdv;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        drive('0, '0, '0, 1'b0, 1'b0, 1'b0);
        set_fixed_payload();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    typedef struct {
        logic [N-1:0] rv, wnr, dv;
        logic         my, mdy, mdv;
        logic [N-1:0] e_yumi, e_resp, e_dyumi;
        logic         e_mv, e_mdv, e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [N-1:0] rv, input logic [N-1:0] wnr, input logic [N-1:0] dv,
                                input logic my, input logic mdy, input logic mdv,
                                input logic [N-1:0] e_yumi, input logic e_mv, input logic [N-1:0] e_resp,
                                input logic [N-1:0] e_dyumi, input logic e_mdv, input logic e_err);
        vec_t v;
        v.rv = rv; v.wnr = wnr; v.dv = dv; v.my = my; v.mdy = mdy; v.mdv = mdv;
        v.e_yumi = e_yumi; v.e_mv = e_mv; v.e_resp = e_resp;
        v.e_dyumi = e_dyumi; v.e_mdv = e_mdv; v.e_err = e_err;
        return v;
    endfunction

    // reference model state
    int m_ptr;
    int rtq[$];
    int wiq[$];
    bit m_err;

    initial begin
        vec_t v;
        // four requesters reading continuously: grants rotate 0,1,2,3,0
        vecs.push_back(mk(4'b1111, 4'b0000, 4'b0000, 1, 0, 0, 4'b0001, 1, 4'b0000, 4'b0000, 0, 0));
        vecs.push_back(mk(4'b1111, 4'b0000, 4'b0000, 1, 0, 0, 4'b0010, 1, 4'b0000, 4'b0000, 0, 0));
        vecs.push_back(mk(4'b1111, 4'b0000, 4'b0000, 1, 0, 0, 4'b0100, 1, 4'b0000, 4'b0000, 0, 0));
        vecs.push_back(mk(4'b1111, 4'b0000, 4'b0000, 1, 0, 0, 4'b1000, 1, 4'b0000, 4'b0000, 0, 0));
        vecs.push_back(mk(4'b1111, 4'b0000, 4'b0000, 1, 0, 0, 4'b0001, 1, 4'b0000, 4'b0000, 0, 0));
        // read data returns in issue order
        vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 0, 0, 1, 4'b0000, 0, 4'b0001, 4'b0000, 0, 0));
        vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 0, 0, 1, 4'b0000, 0, 4'b0010, 4'b0000, 0, 0));
        vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 0, 0, 1, 4'b0000, 0, 4'b0100, 4'b0000, 0, 0));
        vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 0, 0, 1, 4'b0000, 0, 4'b1000, 4'b0000, 0, 0));
        vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 0, 0, 1, 4'b0000, 0, 4'b0001, 4'b0000, 0, 0));
        // requester 1 reads, requester 2 writes (pointer is at 1)
        vecs.push_back(mk(4'b0110, 4'b0100, 4'b0000, 1, 0, 0, 4'b0010, 1, 4'b0000, 4'b0000, 0, 0));
        vecs.push_back(mk(4'b0100, 4'b0100, 4'b0000, 1, 0, 0, 4'b0100, 1, 4'b0000, 4'b0000, 0, 0));
        // head writer has no data yet: other requesters' data_v must not matter
        vecs.push_back(mk(4'b0000, 4'b0000, 4'b1011, 0, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0));
        vecs.push_back(mk(4'b0000, 4'b0000, 4'b0100, 0, 1, 0, 4'b0000, 0, 4'b0000, 4'b0100, 1, 0));
        vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 0, 0, 1, 4'b0000, 0, 4'b0010, 4'b0000, 0, 0));
        // channel stalls: valid held, nothing accepted; then accepted at pointer 3
        vecs.push_back(mk(4'b1111, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 1, 4'b0000, 4'b0000, 0, 0));
        vecs.push_back(mk(4'b1111, 4'b0000, 4'b0000, 1, 0, 0, 4'b1000, 1, 4'b0000, 4'b0000, 0, 0));
        vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 0, 0, 1, 4'b0000, 0, 4'b1000, 4'b0000, 0, 0));
        // data yumi without data valid flags an error the following cycle
        vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 0, 1, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0));
        vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 1));

        apply_reset();
        check("reset error_o", DW'(error_o), DW'(1'b0));
        check("reset mem_v_o", DW'(mem_v_o), DW'(1'b0));

        for (int t = 0; t < vecs.size(); t++) begin
            v = vecs[t];
            drive(v.rv, v.wnr, v.dv, v.my, v.mdy, v.mdv);
            #1;
            check($sformatf("v%0d req_yumi", t), DW'(req_yumi_o), DW'(v.e_yumi));
            check($sformatf("v%0d mem_v", t), DW'(mem_v_o), DW'(v.e_mv));
            check($sformatf("v%0d resp_v", t), DW'(resp_v_o), DW'(v.e_resp));
            check($sformatf("v%0d data_yumi", t), DW'(req_data_yumi_o), DW'(v.e_dyumi));
            check($sformatf("v%0d mem_data_v", t), DW'(mem_data_v_o), DW'(v.e_mdv));
            check($sformatf("v%0d error", t), DW'(error_o), DW'(v.e_err));
            check($sformatf("v%0d resp_data", t), resp_data_o, mem_data_i);
            for (int k = 0; k < N; k++) begin
                if (v.e_yumi[k[IW-1:0]]) begin
                    check($sformatf("v%0d addr", t), DW'(mem_ch_addr_o), DW'(addr_of(k)));
                    check($sformatf("v%0d wnr", t), DW'(mem_write_not_read_o), DW'(v.wnr[k[IW-1:0]]));
                end
                if (v.e_dyumi[k[IW-1:0]])
                    check($sformatf("v%0d mem_data", t), mem_data_o, dat_of(k));
            end
            next_cycle();
        end

        // fill the read-tag FIFO, then a returning beat re-enables issue in the same cycle
        apply_reset();
        for (int i = 0; i < FE; i++) begin
            drive(4'b0001, 4'b0000, 4'b0000, 1, 0, 0);
            #1;
            check($sformatf("fill%0d mem_v", i), DW'(mem_v_o), DW'(1'b1));
            next_cycle();
        end
        drive(4'b0001, 4'b0000, 4'b0000, 1, 0, 0);
        #1;
        check("full mem_v", DW'(mem_v_o), DW'(1'b0));
        check("full req_yumi", DW'(req_yumi_o), DW'(4'b0000));
        mem_data_v_i = 1'b1;
        #1;
        check("full+pop mem_v", DW'(mem_v_o), DW'(1'b1));
        check("full+pop req_yumi", DW'(req_yumi_o), DW'(4'b0001));
        check("full+pop resp_v", DW'(resp_v_o), DW'(4'b0001));
        next_cycle();
        drive('0, '0, '0, 0, 0, 0);
        #1;
        check("post-pop error", DW'(error_o), DW'(1'b0));

        // reset mid-operation with three reads outstanding
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            drive(4'b0111, 4'b0000, 4'b0000, 1, 0, 0);
            next_cycle();
        end
        reset = 1'b0;
        drive(4'b1111, 4'b0000, 4'b1111, 1, 1, 1);
        #1;
        check("in-reset mem_v", DW'(mem_v_o), DW'(1'b0));
        check("in-reset req_yumi", DW'(req_yumi_o), DW'(4'b0000));
        check("in-reset resp_v", DW'(resp_v_o), DW'(4'b0000));
        check("in-reset data_v", DW'(mem_data_v_o), DW'(1'b0));
        check("in-reset data_yumi", DW'(req_data_yumi_o), DW'(4'b0000));
        check("in-reset addr", DW'(mem_ch_addr_o), DW'(0));
        next_cycle();
        check("in-reset error", DW'(error_o), DW'(1'b0));
        next_cycle();
        reset = 1'b1;
        drive(4'b1111, 4'b1111, 4'b0000, 1, 0, 0);
        #1;
        check("post-reset grant", DW'(req_yumi_o), DW'(4'b0001));
        next_cycle();
        drive(4'b0000, 4'b0000, 4'b0000, 0, 0, 1);
        #1;
        check("stale data resp_v", DW'(resp_v_o), DW'(4'b0000));
        next_cycle();
        drive('0, '0, '0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("sticky error %0d", i), DW'(error_o), DW'(1'b1));
            next_cycle();
        end
        apply_reset();
        #1;
        check("error cleared", DW'(error_o), DW'(1'b0));

        // randomized run against the queue model
        m_ptr = 0; rtq.delete(); wiq.delete(); m_err = 0;
        for (int c = 0; c < 1500; c++) begin
            int pct, g, wh;
            bit rt_pop, m_dv, wi_pop, m_mv, acc;
            logic [N-1:0] rv, wnr, dv, e_yumi, e_resp, e_dy;
            logic my, mdy, mdv;
            if (c == 750) begin
                apply_reset();
                m_ptr = 0; rtq.delete(); wiq.delete(); m_err = 0;
            end
            pct = ((c / 250) % 2 == 1) ? 85 : 20;
            rv  = N'($urandom);
            wnr = N'($urandom);
            dv  = N'($urandom);
            my  = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                req_ch_addr_i[i*AW +: AW] = AW'($urandom);
                for (int w = 0; w < DW / 32; w++) req_data_i[i*DW + w*32 +: 32] = $urandom;
            end
            for (int w = 0; w < DW / 32; w++) mem_data_i[w*32 +: 32] = $urandom;
            if (rtq.size() > 0) mdv = ($urandom_range(0, 99) < pct);
            else                mdv = ($urandom_range(0, 299) == 0);
            wh   = (wiq.size() > 0) ? wiq[0] : 0;
            m_dv = (wiq.size() > 0) && dv[wh[IW-1:0]];
            if (m_dv) mdy = ($urandom_range(0, 3) != 0);
            else      mdy = ($urandom_range(0, 299) == 0);
            rt_pop = mdv && (rtq.size() > 0);
            wi_pop = m_dv && mdy;
            g = -1;
            for (int k = 0; k < N; k++) begin
                int cand;
                cand = (m_ptr + k) % N;
                if (g < 0 && rv[cand[IW-1:0]]) g = cand;
            end
            m_mv = (g >= 0) && (rtq.size() < FE || rt_pop) && (wiq.size() < FE || wi_pop);
            acc  = m_mv && my;
            e_yumi = acc ? (N'(1) << g) : '0;
            e_resp = rt_pop ? (N'(1) << rtq[0]) : '0;
            e_dy   = wi_pop ? (N'(1) << wh) : '0;

            drive(rv, wnr, dv, my, mdy, mdv);
            #1;
            check($sformatf("r%0d mem_v", c), DW'(mem_v_o), DW'(m_mv));
            check($sformatf("r%0d req_yumi", c), DW'(req_yumi_o), DW'(e_yumi));
            check($sformatf("r%0d resp_v", c), DW'(resp_v_o), DW'(e_resp));
            check($sformatf("r%0d mem_data_v", c), DW'(mem_data_v_o), DW'(m_dv));
            check($sformatf("r%0d data_yumi", c), DW'(req_data_yumi_o), DW'(e_dy));
            check($sformatf("r%0d error", c), DW'(error_o), DW'(m_err));
            if (m_mv) begin
                check($sformatf("r%0d addr", c), DW'(mem_ch_addr_o), DW'(req_ch_addr_i[g*AW +: AW]));
                check($sformatf("r%0d wnr", c), DW'(mem_write_not_read_o), DW'(wnr[g[IW-1:0]]));
            end
            if (m_dv) check($sformatf("r%0d mem_data", c), mem_data_o, req_data_i[wh*DW +: DW]);
            if (rt_pop) check($sformatf("r%0d resp_data", c), resp_data_o, mem_data_i);

            if ((mdv && rtq.size() == 0) || (mdy && !m_dv)) m_err = 1;
            if (rt_pop) void'(rtq.pop_front());
            if (wi_pop) void'(wiq.pop_front());
            if (acc) begin
                if (wnr[g[IW-1:0]]) wiq.push_back(g);
                else                rtq.push_back(g);
                m_ptr = (g + 1) % N;
            end
            next_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bsg_dramsim3_ch_arbiter.md
BSG_DRAMSIM3_CH_ARBITER -- requirements
Module: bsg_dramsim3_ch_arbiter

Interface
REQ-001 SHALL have parameter num_req_p, default 4, number of requesters sharing one DRAM channel (legal 2..8).
REQ-002 SHALL have parameter channel_addr_width_p, default 29, channel byte-address width.
REQ-003 SHALL have parameter data_width_p, default 256, data beat width.
REQ-004 SHALL have parameter fifo_els_p, default 16, depth of the read-tag FIFO and of the write-id FIFO (power of 2).
REQ-005 SHALL have ports (clock and reset first):
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, synchronous, active-low; clock clk.
- req_v_i  in  num_req_p  per-requester command valid.
- req_write_not_read_i  in  num_req_p  1 = write, 0 = read.
- req_ch_addr_i  in  num_req_p x channel_addr_width_p  command address.
- req_yumi_o  out  num_req_p  command accepted this cycle, one-hot or zero.
- req_data_v_i  in  num_req_p  write data valid.
- req_data_i  in  num_req_p x data_width_p  write data.
- req_data_yumi_o  out  num_req_p  write data consumed, one-hot or zero.
- resp_v_o  out  num_req_p  read data valid, one-hot or zero.
- resp_data_o  out  data_width_p  read data, shared by all requesters.
- mem_v_o, mem_write_not_read_o, mem_ch_addr_o  out  1/1/channel_addr_width_p  channel command.
- mem_yumi_i  in  1  channel accepts command (same cycle as mem_v_o).
- mem_data_v_o, mem_data_o  out  1/data_width_p  write data to channel.
- mem_data_yumi_i  in  1  channel consumes write data.
- mem_data_v_i, mem_data_i  in  1/data_width_p  read data from channel, returned in command-acceptance order.
- error_o  out  1  sticky protocol error.

Function
REQ-006 SHALL select the command through a round-robin arbiter; the priority pointer starts at requester 0 and, on each mem_yumi_i, moves to (granted index + 1) mod num_req_p.
REQ-007 SHALL drive mem_v_o = 1 only when some req_v_i is set, the read-tag FIFO is not full and the write-id FIFO is not full; mem_write_not_read_o/mem_ch_addr_o SHALL come from the granted requester.
REQ-008 SHALL assert req_yumi_o[g] = mem_yumi_i & mem_v_o for granted g only; grant is combinational, zero added latency.
REQ-009 SHALL hold the pointer and both FIFOs unchanged when mem_v_o = 1 and mem_yumi_i = 0; grant may change next cycle if req_v_i changes.
REQ-010 SHALL push the granted index into the read-tag FIFO on an accepted read, and into the write-id FIFO on an accepted write.
REQ-011 SHALL drive mem_data_v_o = write-id FIFO non-empty & req_data_v_i[head]; mem_data_o = req_data_i[head]; req_data_yumi_o[head] = mem_data_yumi_i & mem_data_v_o; the FIFO pops on that yumi.
REQ-012 SHALL, on mem_data_v_i with the read-tag FIFO non-empty, assert resp_v_o[head] for that cycle, pass mem_data_i to resp_data_o, and pop the FIFO; resp has no backpressure.
REQ-013 SHALL allow push and pop of the same FIFO in the same cycle, including when the FIFO is full. A pop frees the entry in that cycle, so mem_v_o is not blocked by a full FIFO when a pop happens in the same cycle.
REQ-014 SHALL set error_o and drop the beat when mem_data_v_i = 1 with the read-tag FIFO empty, or when mem_data_yumi_i = 1 with mem_data_v_o = 0.
REQ-015 SHALL keep resp_data_o = mem_data_i at all times, so it is don't-care when resp_v_o = 0.

Reset
REQ-016 SHALL, while reset = 0 at a rising clk edge, empty both FIFOs, set the pointer to 0, clear error_o, and force req_yumi_o, req_data_yumi_o, resp_v_o, mem_v_o and mem_data_v_o to 0.
REQ-017 SHALL discard any in-flight commands and tags when reset is asserted mid-operation; read data arriving after reset SHALL set error_o.

Verification
REQ-018 All 4 requesters issue reads continuously, mem_yumi_i = 1 -> grants in order 0,1,2,3,0; resp_v_o returns in the same order.
REQ-019 Requester 2 writes 0x40 while requester 1 reads 0x80, then mem_data_yumi_i = 1 -> requester 2's data appears on mem_data_o; req_data_yumi_o = 0b0100.
REQ-020 Issue 16 reads with no read data returned -> mem_v_o = 0 on the 17th; one mem_data_v_i re-enables issue the same cycle.
REQ-021 mem_data_v_i with no outstanding reads -> error_o = 1 and stays 1 until reset.
REQ-022 Assert reset = 0 with 3 reads outstanding -> all outputs 0, the next grant goes to requester 0, and later read data sets error_o.
